md_sequencer: RTL

MD_SEQUENCER -- requirements
Module: md_sequencer

---
 rtl/md_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : md_sequencer
// Description : Multi-cycle mult/div sequencer owning the HI/LO registers.
//               Results are computed at issue, held in shadow registers and
//               committed to HI/LO when the busy period expires.
// Revision    : 1.0 - initial release
// ============================================================================
module md_sequencer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] c_OP_MULT  = 4'b0001;
    localparam logic [3:0] c_OP_MULTU = 4'b0010;
    localparam logic [3:0] c_OP_DIV   = 4'b0011;
    localparam logic [3:0] c_OP_DIVU  = 4'b0100;
    localparam logic [3:0] c_OP_MTHI  = 4'b0101;
    localparam logic [3:0] c_OP_MTLO  = 4'b0110;

    localparam logic [3:0] c_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] c_DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_hi, w_hi_nxt;
    logic [31:0] r_lo, w_lo_nxt;
    logic [31:0] r_hh, w_hh_nxt;
    logic [31:0] r_lh, w_lh_nxt;
    logic        r_wr, w_wr_nxt;

    // Sign-extended 64-bit multiply yields the exact signed product bits.
    logic [63:0] w_prod_s, w_prod_u;
    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    logic        w_b_zero;
    logic [31:0] w_divu_b, w_qu, w_ru;
    assign w_b_zero = (B == 32'd0);
    assign w_divu_b = w_b_zero ? 32'd1 : B;
    assign w_qu     = A / w_divu_b;
    assign w_ru     = A % w_divu_b;

    // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000.
    logic [31:0] w_abs_a, w_abs_b, w_qm, w_rm, w_qs, w_rs;
    assign w_abs_a = A[31] ? (~A + 32'd1) : A;
    assign w_abs_b = w_b_zero ? 32'd1 : (B[31] ? (~B + 32'd1) : B);
    assign w_qm    = w_abs_a / w_abs_b;
    assign w_rm    = w_abs_a % w_abs_b;
    assign w_qs    = (A[31] ^ B[31]) ? (~w_qm + 32'd1) : w_qm;
    assign w_rs    = A[31] ? (~w_rm + 32'd1) : w_rm;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_hh_nxt    = r_hh;
        w_lh_nxt    = r_lh;
        w_wr_nxt    = r_wr;
        unique case (r_state)
            IDLE: begin
                case (start)
                    c_OP_MULT: begin
                        w_hh_nxt    = w_prod_s[63:32];
                        w_lh_nxt    = w_prod_s[31:0];
                        w_wr_nxt    = 1'b1;
                        w_cnt_nxt   = c_MULT_CNT;
                        w_state_nxt = RUN;
                    end
                    c_OP_MULTU: begin
                        w_hh_nxt    = w_prod_u[63:32];
                        w_lh_nxt    = w_prod_u[31:0];
                        w_wr_nxt    = 1'b1;
                        w_cnt_nxt   = c_MULT_CNT;
                        w_state_nxt = RUN;
                    end
                    c_OP_DIV: begin
                        w_hh_nxt    = w_rs;
                        w_lh_nxt    = w_qs;
                        w_wr_nxt    = ~w_b_zero;
                        w_cnt_nxt   = c_DIV_CNT;
                        w_state_nxt = RUN;
                    end
                    c_OP_DIVU: begin
                        w_hh_nxt    = w_ru;
                        w_lh_nxt    = w_qu;
                        w_wr_nxt    = ~w_b_zero;
                        w_cnt_nxt   = c_DIV_CNT;
                        w_state_nxt = RUN;
                    end
                    c_OP_MTHI: w_hi_nxt = A;
                    c_OP_MTLO: w_lo_nxt = A;
                    default: ;
                endcase
            end
            RUN: begin
                // Start codes are deliberately ignored while running.
                if (r_cnt <= 4'd1) begin
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = IDLE;
                    if (r_wr) begin
                        w_hi_nxt = r_hh;
                        w_lo_nxt = r_lh;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_hh    <= 32'd0;
            r_lh    <= 32'd0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_hh    <= w_hh_nxt;
            r_lh    <= w_lh_nxt;
            r_wr    <= w_wr_nxt;
        end
    end

    assign busy = (r_state == RUN);
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire
